// File: rtl/rx4.sv
// rx4: UART 8N1 receiver that packs four consecutive bytes into one 32-bit
// word. The first byte received lands in data_out[7:0], the fourth in
// data_out[31:24]. A one-cycle valid pulse marks each completed word.
// A bad stop bit pulses frame_err and throws away the partial word.
//
// Optional build macro RX4_TIMEOUT_EN: when it is defined, a partial word is
// discarded (with a frame_err pulse) after TIMEOUT_BITS idle bit-times.
// When it is undefined, a partial word waits indefinitely for its remaining
// bytes.
module rx4 #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // Centre sampling needs at least a few cycles per bit.
    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("rx4: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic             din_p0;
    logic             din_p1;
    logic             din_p2;
    logic             fall_edge;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       lane0;
    logic [7:0]       lane1;
    logic [7:0]       lane2;

    // din is asynchronous: two flops for metastability, a third to hold the
    // previous synchronised value for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_p0 <= 1'b1;
            din_p1 <= 1'b1;
            din_p2 <= 1'b1;
        end else begin
            din_p0 <= din;
            din_p1 <= din_p0;
            din_p2 <= din_p1;
        end
    end

    assign fall_edge = din_p2 & ~din_p1;

`ifdef RX4_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES) + 1;

    logic [TO_W-1:0] tcnt;

    // Idle time spent with a partial word pending; restarts on any start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state != S_IDLE || byte_idx == 2'd0 || fall_edge || timeout_hit) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == S_IDLE) && (byte_idx != 2'd0) &&
                         (tcnt == TO_W'(TO_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Receive state machine: bit timing, byte assembly, word hand-off and
    // all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            lane0     <= '0;
            lane1     <= '0;
            lane2     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (fall_edge) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end else if (timeout_hit) begin
                        byte_idx  <= 2'd0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!din_p1) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Glitch: no error, partial word kept. Only drop
                            // busy if no word was in progress.
                            state <= S_IDLE;
                            if (byte_idx == 2'd0) begin
                                busy <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt       <= '0;
                        shift_reg <= {din_p1, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (din_p1) begin
                            state <= S_IDLE;
                            case (byte_idx)
                                2'd0: lane0 <= shift_reg;
                                2'd1: lane1 <= shift_reg;
                                2'd2: lane2 <= shift_reg;
                                default: begin
                                    // Last byte goes straight into the word so a
                                    // partial word never reaches data_out.
                                    data_out <= {shift_reg, lane2, lane1, lane0};
                                    valid    <= 1'b1;
                                    busy     <= 1'b0;
                                end
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= 2'd0;
                            busy      <= 1'b0;
                            state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not
                    // taken as a new start bit.
                    cnt <= '0;
                    if (din_p1) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx4.sv
// Testbench for rx4: directed and random UART traffic at 8 clocks per bit,
// checked against a byte-queue model of the word assembly rules.
module tb_rx4;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b1;
    logic [31:0] data_out;
    logic        valid;
    logic        frame_err;
    logic        busy;

    rx4 #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(40)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .data_out (data_out),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed events
    logic [31:0] got_q[$];
    int          got_ferr = 0;
    int          bad_both = 0;
    int          bad_busy = 0;
    int          bad_hold = 0;
    logic [31:0] last_data = 32'h0;

    // Reference model: bytes accepted so far for the current word
    logic [7:0]  part_q[$];
    logic [31:0] exp_q[$];
    int          exp_ferr = 0;

    // Monitor outputs away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            last_data = 32'h0;
        end else begin
            if (valid) begin
                got_q.push_back(data_out);
                last_data = data_out;
                if (busy) bad_busy++;
            end else if (data_out !== last_data) begin
                bad_hold++;
            end
            if (frame_err) got_ferr++;
            if (valid && frame_err) bad_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        part_q.push_back(b);
        if (part_q.size() == 4) begin
            exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
            part_q.delete();
        end
    endtask

    task automatic model_ferr();
        part_q.delete();
        exp_ferr++;
    endtask

    task automatic drive_bit(input logic v);
        din = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b, input int gap_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        model_byte(b);
        din = 1'b1;
        repeat (gap_bits * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_bits);
        for (int i = 0; i < 4; i++) send_good(w[8*i +: 8], gap_bits);
    endtask

    task automatic settle(input string tag);
        int n;
        for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        chk({tag, " word count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s word %0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " frame_err count"}, 32'(got_ferr), 32'(exp_ferr));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  pb;
        logic [31:0] rw;

        // Reset state
        rst = 1'b1;
        din = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset data_out", data_out, 32'h0);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Back-to-back bytes of one word
        send_good(8'h78, 0);
        chk("busy between bytes", 32'(busy), 32'h1);
        send_good(8'h56, 0);
        send_good(8'h34, 0);
        send_good(8'h12, 0);
        settle("b2b");
        chk("busy after word", 32'(busy), 32'h0);
        chk("b2b data_out", data_out, 32'h12345678);

        // Two words with 3 idle bits between bytes
        send_word(32'hDEADBEEF, 3);
        send_word(32'h00000001, 3);
        settle("gap3");
        chk("gap3 data_out", data_out, 32'h00000001);

        // Short glitch in idle, then a clean word
        din = 1'b0;
        repeat (2) @(negedge clk);
        din = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_word(32'hA5A5A5A5, 0);
        settle("glitch");

        // Bad stop bit mid-word with a long break, then a clean word
        send_good(8'h11, 0);
        send_good(8'h22, 0);
        drive_bit(1'b0);
        pb = 8'h33;
        for (int i = 0; i < 8; i++) drive_bit(pb[i]);
        din = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        model_ferr();
        din = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_word(32'hCAFEF00D, 1);
        settle("framing");
        chk("framing data_out", data_out, 32'hCAFEF00D);

        // Random words with random gaps
        for (int k = 0; k < 3; k++) begin
            rw = $urandom;
            send_word(rw, $urandom_range(0, 3));
        end
        settle("random");

        // Reset during bit 4 of byte 2
        send_good(8'hAA, 0);
        send_good(8'hBB, 0);
        pb = 8'hC6;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(pb[i]);
        din = pb[4];
        repeat (CPB / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midframe rst data_out", data_out, 32'h0);
        chk("midframe rst valid", 32'(valid), 32'h0);
        chk("midframe rst frame_err", 32'(frame_err), 32'h0);
        chk("midframe rst busy", 32'(busy), 32'h0);
        din = 1'b1;
        part_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_word(32'h01020304, 0);
        settle("rst recovery");
        chk("rst recovery data_out", data_out, 32'h01020304);

        // Long idle gap after a single byte
        send_good(8'h55, 0);
        repeat (41 * CPB) @(negedge clk);
`ifdef RX4_TIMEOUT_EN
        model_ferr();
`endif
        send_good(8'h04, 0);
        send_good(8'h03, 0);
        send_good(8'h02, 0);
        send_good(8'h01, 0);
        settle("idle gap");

        // Whole-run invariants
        chk("valid with frame_err", 32'(bad_both), 32'h0);
        chk("busy high at valid", 32'(bad_busy), 32'h0);
        chk("data_out changed without valid", 32'(bad_hold), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
